// File: rtl/weight_streamer.sv
// weight_streamer
//   Captures one KERNEL_SIZE*KERNEL_SIZE x DATA_WIDTH vector on an accepted
//   start. Sends it out as BUS_WIDTH-bit AXI-Stream beats, MSB-first. The
//   first beat carries the zero padding. A loader that shifts each beat in at
//   the bottom rebuilds data_in bit-exactly.
//
//   Optional feature macro: WEIGHT_STREAMER_TLAST_EN
//     defined   : m_axis_tlast marks the final beat of each vector
//     undefined : m_axis_tlast tied low; the receiver counts beats
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   data_in         : parallel vector, sampled only when start is accepted
//   start           : send request, honoured only in IDLE
//   busy            : high while beats are outstanding (SEND)
//   done            : one-cycle pulse after the final beat handshakes
//   m_axis_tdata    : beat data
//   m_axis_tvalid   : beat valid
//   m_axis_tready   : downstream ready
//   m_axis_tlast    : final-beat marker
module weight_streamer #(
    parameter  int KERNEL_SIZE   = 16,
    parameter  int DATA_WIDTH    = 8,
    parameter  int BUS_WIDTH     = 32,
    localparam int REQUIRED_BITS = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH,
    localparam int NUM_TRANSFERS = (REQUIRED_BITS + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int PADDED_SIZE   = NUM_TRANSFERS * BUS_WIDTH,
    localparam int CNT_W         = $clog2(NUM_TRANSFERS) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REQUIRED_BITS-1:0] data_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [BUS_WIDTH-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TRANSFERS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [PADDED_SIZE-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        tvalid_d = tvalid_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Zero extension puts the padding in the MSBs, so it
                    // leaves first.
                    buf_d    = PADDED_SIZE'(data_in);
                    cnt_d    = '0;
                    state_d  = SEND;
                    busy_d   = 1'b1;
                    tvalid_d = 1'b1;
                end
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    buf_d = buf_q << BUS_WIDTH;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
            end
        endcase

`ifdef WEIGHT_STREAMER_TLAST_EN
        // Registered alongside tvalid, so tlast holds steady through stalls.
        tlast_d = tvalid_d && (cnt_d == LAST_CNT);
`else
        tlast_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    // The top slice comes straight from a flop. After reset, and after a full
    // transfer, buf_q is all zeros, so tdata idles at zero.
    assign m_axis_tdata  = buf_q[PADDED_SIZE-1 -: BUS_WIDTH];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_weight_streamer.sv
// Bench for weight_streamer: a default-size instance (64 beats) and a
// KERNEL_SIZE=3 instance (72-bit vector padded to 3 beats).
module tb_weight_streamer;

    localparam int AB = 2048;
    localparam int NB = 64;

`ifdef WEIGHT_STREAMER_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_start = 1'b0;
    logic [AB-1:0] a_din   = '0;
    logic          a_busy, a_done, a_tvalid, a_tlast;
    logic          a_tready = 1'b0;
    logic [31:0]   a_tdata;

    logic          b_start = 1'b0;
    logic [71:0]   b_din   = '0;
    logic          b_busy, b_done, b_tvalid, b_tlast;
    logic          b_tready = 1'b0;
    logic [31:0]   b_tdata;

    int n_chk  = 0;
    int n_fail = 0;

    weight_streamer u_a (
        .clk(clk), .rst(rst), .data_in(a_din), .start(a_start),
        .busy(a_busy), .done(a_done), .m_axis_tdata(a_tdata),
        .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready), .m_axis_tlast(a_tlast)
    );

    weight_streamer #(.KERNEL_SIZE(3)) u_b (
        .clk(clk), .rst(rst), .data_in(b_din), .start(b_start),
        .busy(b_busy), .done(b_done), .m_axis_tdata(b_tdata),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready), .m_axis_tlast(b_tlast)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AB-1:0] rand_vec();
        logic [AB-1:0] v;
        for (int i = 0; i < NB; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: beat i is the i-th 32-bit slice counted from the MSB
    // of the zero-padded vector.
    function automatic logic [31:0] ref_a(input logic [AB-1:0] v, input int i);
        return v[AB-1-32*i -: 32];
    endfunction

    function automatic logic [31:0] ref_b(input logic [71:0] v, input int i);
        logic [95:0] p;
        p = {24'd0, v};
        return p[95-32*i -: 32];
    endfunction

    // Start a vector on u_a and check the first beat is up one cycle later.
    task automatic launch_a(input logic [AB-1:0] v);
        a_din   = v;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_din   = rand_vec();
        chk("lat_vld",  64'(a_tvalid), 64'd1);
        chk("lat_busy", 64'(a_busy),   64'd1);
        chk("lat_data", 64'(a_tdata),  64'(ref_a(v, 0)));
        chk("lat_done", 64'(a_done),   64'd0);
    endtask

    // Receive one vector from u_a. Returns at the cycle after the last
    // handshake. The loop also rebuilds the vector the way a bottom-shifting
    // loader would.
    task automatic drain_a(input logic [AB-1:0] v, input bit rnd, input bit ign,
                           output logic [AB-1:0] recon, output int cyc);
        int   idx = 0;
        int   nd  = 0;
        bit   ps  = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        recon = '0;
        cyc   = 0;
        while (idx < NB && cyc < 4000) begin
            if (ps) begin
                chk("stall_vld",  64'(a_tvalid), 64'd1);
                chk("stall_data", 64'(a_tdata),  64'(pd));
                chk("stall_last", 64'(a_tlast),  64'(pl));
            end
            if (a_done) nd++;
            a_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            a_din    = rand_vec();
            if (ign) a_start = 1'($urandom_range(0, 1));
            ps = a_tvalid && !a_tready;
            pd = a_tdata;
            pl = a_tlast;
            if (a_tvalid && a_tready) begin
                chk("beat", 64'(a_tdata), 64'(ref_a(v, idx)));
                chk("last", 64'(a_tlast), 64'(TL && idx == NB - 1));
                recon = {recon[AB-33:0], a_tdata};
                idx++;
            end
            tick();
            cyc++;
        end
        a_start = 1'b0;
        chk("beats",      64'(idx),      64'(NB));
        chk("early_done", 64'(nd),       64'd0);
        chk("done",       64'(a_done),   64'd1);
        chk("end_vld",    64'(a_tvalid), 64'd0);
        chk("end_busy",   64'(a_busy),   64'd0);
    endtask

    initial begin : wdog
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : main
        logic [AB-1:0] va, vb, rc;
        logic [71:0]   sb;
        logic [95:0]   t96;
        int            cyc;

        // Reset holds everything low even with start and tready asserted.
        rst = 1'b1; a_start = 1'b1; b_start = 1'b1; a_tready = 1'b1; b_tready = 1'b1;
        a_din = rand_vec();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_vld",  64'(a_tvalid), 64'd0);
            chk("rst_busy", 64'(a_busy),   64'd0);
            chk("rst_done", 64'(a_done),   64'd0);
            chk("rst_data", 64'(a_tdata),  64'd0);
            chk("rst_last", 64'(a_tlast),  64'd0);
            chk("rst_bvld", 64'(b_tvalid), 64'd0);
        end
        rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
        tick();
        chk("post_rst_vld",  64'(a_tvalid), 64'd0);
        chk("post_rst_bvld", 64'(b_tvalid), 64'd0);

        // Padded 3-beat vectors, tready held high.
        for (int k = 0; k < 3; k++) begin
            t96 = {$urandom, $urandom, $urandom};
            sb  = (k == 0) ? 72'h0123456789ABCDEF11 : t96[71:0];
            b_din = sb; b_start = 1'b1;
            tick();
            b_start = 1'b0; t96 = {$urandom, $urandom, $urandom}; b_din = t96[71:0];
            for (int i = 0; i < 3; i++) begin
                chk("b_vld",  64'(b_tvalid), 64'd1);
                chk("b_beat", 64'(b_tdata),  64'(ref_b(sb, i)));
                chk("b_last", 64'(b_tlast),  64'(TL && i == 2));
                chk("b_done_early", 64'(b_done), 64'd0);
                tick();
            end
            chk("b_done",   64'(b_done),   64'd1);
            chk("b_endvld", 64'(b_tvalid), 64'd0);
            chk("b_busy",   64'(b_busy),   64'd0);
            tick();
            chk("b_done_1cyc", 64'(b_done), 64'd0);
        end
        chk("b_const_beats", 64'(ref_b(72'h0123456789ABCDEF11, 1)), 64'h23456789);

        // Random backpressure with loopback reconstruction.
        for (int k = 0; k < 3; k++) begin
            va = rand_vec();
            launch_a(va);
            drain_a(va, 1'b1, 1'b0, rc, cyc);
            chk("loopback", 64'(rc == va), 64'd1);
            tick();
            chk("done_1cyc", 64'(a_done), 64'd0);
            tick();
        end

        // Full throughput: one beat per cycle.
        va = rand_vec();
        launch_a(va);
        drain_a(va, 1'b0, 1'b0, rc, cyc);
        chk("thruput", 64'(cyc), 64'(NB));
        tick();

        // Reset mid-stream after 10 beats.
        va = rand_vec();
        launch_a(va);
        a_tready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_data", 64'(a_tdata), 64'(ref_a(va, 10)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_vld",  64'(a_tvalid), 64'd0);
        chk("mid_busy", 64'(a_busy),   64'd0);
        chk("mid_done", 64'(a_done),   64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_quiet_vld",  64'(a_tvalid), 64'd0);
            chk("mid_quiet_done", 64'(a_done),   64'd0);
        end
        va = rand_vec();
        launch_a(va);
        drain_a(va, 1'b1, 1'b0, rc, cyc);
        tick();

        // Start ignored while busy; back-to-back launch from the done cycle.
        va = rand_vec();
        vb = rand_vec();
        launch_a(va);
        drain_a(va, 1'b1, 1'b1, rc, cyc);
        chk("ign_loopback", 64'(rc == va), 64'd1);
        launch_a(vb);
        drain_a(vb, 1'b1, 1'b0, rc, cyc);
        chk("b2b_loopback", 64'(rc == vb), 64'd1);
        tick();
        chk("final_done", 64'(a_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_streamer.md
# weight_streamer

Transmit-side counterpart of the AXI-Stream weight loader. It captures one wide parallel vector of KERNEL_SIZE×KERNEL_SIZE words, each DATA_WIDTH bits wide, on a start request. It then serializes the vector onto an AXI-Stream master as BUS_WIDTH-bit beats, in exactly the order the loader expects. It sits at the output of compute/storage blocks in the map-inflation datapath and feeds kernels or result maps downstream (for example, a loader in another tile or the DMA).

## Interface
- KERNEL_SIZE, 16, kernel edge length; vector holds KERNEL_SIZE² elements
- DATA_WIDTH, 8, bits per element
- BUS_WIDTH, 32, AXI-Stream data width
- Derived: REQUIRED_BITS = KERNEL_SIZE²·DATA_WIDTH; NUM_TRANSFERS = ceil(REQUIRED_BITS/BUS_WIDTH); PADDED_SIZE = NUM_TRANSFERS·BUS_WIDTH
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  REQUIRED_BITS  parallel vector, sampled only on an accepted start
- start  input  1  request to send data_in; honoured only in IDLE
- busy  output  1  high while in SEND
- done  output  1  one-cycle pulse after the final beat handshakes
- m_axis_tdata  output  BUS_WIDTH  beat data
- m_axis_tvalid  output  1  beat valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  final-beat marker (see Configuration)

## Operation
- Internal state: PADDED_SIZE-bit shift register `buf`, transfer counter of $clog2(NUM_TRANSFERS)+1 bits, and a 2-state FSM (IDLE, SEND).
- IDLE: busy=0, tvalid=0. When start=1, the block loads `buf` with data_in zero-extended to PADDED_SIZE (padding in the MSBs), clears the counter, and moves to SEND.
- SEND: m_axis_tdata = buf[PADDED_SIZE-1 -: BUS_WIDTH], so the beat order is MSB-first and the first beat carries the padding. This is the inverse of the loader's shift-in-at-bottom, so a loader receiving the stream reconstructs data_in bit-exactly.
- On each handshake (tvalid & tready):
  - `buf` shifts left by BUS_WIDTH, with zeros filling the bottom.
  - The counter increments.
  - If the counter was NUM_TRANSFERS-1, the FSM goes to IDLE and done is pulsed.
- start while in SEND is ignored; no queuing.
- data_in changes after capture have no effect on the beats in flight.
- Invalid or unreachable state encodings recover to IDLE.

## Timing
- Reset values: busy=0, done=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, counter=0, `buf`=0, FSM in IDLE. Reset is taken at the next edge regardless of state.
- Reset mid-transfer: tvalid drops at the next edge with no further beats. No done pulse is issued for the aborted vector.
- Latency: start sampled at edge N gives tvalid=1 with beat 0 from edge N+1 onward.
- Throughput: with tready held high, one beat per cycle; NUM_TRANSFERS consecutive cycles of tvalid.
- Handshake rules:
  - Once raised, tvalid stays high until the beat is accepted.
  - tdata and tlast are stable while tvalid & !tready.
  - tvalid never depends combinationally on tready.
- Final beat accepted at edge M: at M+1, tvalid=0, busy=0, done=1 for exactly that cycle.
- Back-to-back: start asserted in the done cycle is accepted, because the FSM is already in IDLE. The first beat of the next vector follows one cycle later, so there is a one-cycle bubble between vectors.
- Boundary case: NUM_TRANSFERS=1 sends a single beat, with tlast high on it.

## Configuration
- WEIGHT_STREAMER_TLAST_EN defined: m_axis_tlast=1 exactly on the beat where the counter equals NUM_TRANSFERS-1 (while tvalid), and 0 otherwise.
- Not defined: m_axis_tlast is tied to 0. Downstream must count beats, as the loader does. All other behaviour is identical.

## Test plan
- Reset defaults: hold rst for 3 cycles while tready=1 and start=1 → all outputs 0, no tvalid during reset or in the cycle after reset is released.
- Padded vector, default flow, with KERNEL_SIZE=3, DATA_WIDTH=8, BUS_WIDTH=32, data_in=72'h0123456789ABCDEF11, and tready held high:
  - beats are 0x00000001, 0x23456789, 0xABCDEF11 on 3 consecutive cycles;
  - tlast on beat 3 only (with the macro defined);
  - done pulses one cycle later.
- Backpressure with default parameters (64 beats): toggle tready in a random pattern → tdata and tvalid stay stable through every stall; all 64 beats arrive in order; done pulses exactly once.
- Loopback: connect to a weight loader (KERNEL_SIZE=16, DATA_WIDTH=8, BUS_WIDTH=32) and send a random 2048-bit vector → the loader's weights_out equals data_in once the loader's loading signal drops.
- Reset mid-stream: assert rst after beat 10 of 64 → tvalid=0 and busy=0 from the next cycle; no done pulse. A following start sends all 64 beats from beat 0.
- start while busy, then back-to-back vectors:
  - start pulses with vector B during vector A's transfer are ignored, so only A is sent;
  - start asserted in A's done cycle launches B;
  - B's first beat appears two cycles after A's last handshake.
